// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage of the RV32I out-of-order core.
//
// Holds the PC and requests one instruction at a time from the icache. Each
// fetched instruction is pushed to the instruction queue together with its PC
// and the predicted-taken bit. The next PC is chosen from one of these:
//   - sequential (pc+4)
//   - the predicted branch target
//   - the JAL target
// On a JALR the unit stalls until the reorder buffer redirects it. A ROB
// redirect takes priority over every other action.
//
// Ports:
//   clockIn, resetIn            clock, asynchronous active-high reset
//   icacheReq/icacheAddr        one-cycle fetch request and its address (= pc)
//   icacheValid/icacheInstr     one-cycle icache response
//   predInstrValid/predAddr     lookup request to the branch predictor
//   predJump                    predictor taken bit (registered lookup of pc)
//   queueFull                   instruction queue back-pressure
//   pushValid/pushInstr/        push into the instruction queue
//   pushPc/pushJump
//   redirectValid/redirectAddr  ROB redirect (misprediction / JALR target)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clockIn,
  input  logic        resetIn,
  output logic        icacheReq,
  output logic [31:0] icacheAddr,
  input  logic        icacheValid,
  input  logic [31:0] icacheInstr,
  output logic        predInstrValid,
  output logic [31:0] predAddr,
  input  logic        predJump,
  input  logic        queueFull,
  output logic        pushValid,
  output logic [31:0] pushInstr,
  output logic [31:0] pushPc,
  output logic        pushJump,
  input  logic        redirectValid,
  input  logic [31:0] redirectAddr
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT     = 3'd1,
    S_DISPATCH = 3'd2,
    S_STALL    = 3'd3,
    S_DROP     = 3'd4
  } state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [6:0]  opcode_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_j_s;

  assign opcode_s = instr_q[6:0];
  assign imm_b_s  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                     instr_q[11:8], 1'b0};
  assign imm_j_s  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                     instr_q[30:21], 1'b0};

  // State, PC and instruction registers.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state logic; a redirect overrides every per-state action.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (redirectValid) begin
      pc_d = redirectAddr;
      // A request is still in flight unless its response arrives this very
      // cycle. In that case the response is consumed (discarded) here, so the
      // unit can fetch again immediately instead of waiting for a second
      // response that will never come.
      if (((state_q == S_WAIT) || (state_q == S_DROP)) && !icacheValid) begin
        state_d = S_DROP;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (icacheValid) begin
            instr_d = icacheInstr;
            state_d = S_DISPATCH;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DISPATCH: begin
          if (!queueFull) begin
            case (opcode_s)
              OP_BRANCH: begin
                pc_d    = predJump ? (pc_q + imm_b_s) : (pc_q + 32'd4);
                state_d = S_FETCH;
              end
              OP_JAL: begin
                pc_d    = pc_q + imm_j_s;
                state_d = S_FETCH;
              end
              OP_JALR: begin
                // The target is unknown until the ROB resolves it.
                state_d = S_STALL;
              end
              default: begin
                pc_d    = pc_q + 32'd4;
                state_d = S_FETCH;
              end
            endcase
          end else begin
            state_d = S_DISPATCH;
          end
        end
        S_STALL: begin
          state_d = S_STALL;
        end
        S_DROP: begin
          if (icacheValid) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DROP;
          end
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // Outputs, decoded from the current state and registers.
  always_comb begin
    icacheReq      = (state_q == S_FETCH);
    icacheAddr     = pc_q;
    predInstrValid = (state_q == S_WAIT);
    predAddr       = pc_q;
    pushValid      = (state_q == S_DISPATCH) && !queueFull && !redirectValid;
    pushInstr      = instr_q;
    pushPc         = pc_q;
    case (opcode_s)
      OP_BRANCH: pushJump = predJump;
      OP_JAL:    pushJump = 1'b1;
      default:   pushJump = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        icacheReq;
  logic [31:0] icacheAddr;
  logic        icacheValid;
  logic [31:0] icacheInstr;
  logic        predInstrValid;
  logic [31:0] predAddr;
  logic        predJump;
  logic        queueFull;
  logic        pushValid;
  logic [31:0] pushInstr;
  logic [31:0] pushPc;
  logic        pushJump;
  logic        redirectValid;
  logic [31:0] redirectAddr;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] ADDI    = 32'h0010_0093;
  localparam logic [31:0] BEQ_M8  = 32'hFE00_0CE3;
  localparam logic [31:0] JAL_800 = 32'h0010_006F;
  localparam logic [31:0] JAL_8   = 32'h0080_006F;
  localparam logic [31:0] JALR    = 32'h0000_8067;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clockIn       (clk),
    .resetIn       (rst),
    .icacheReq     (icacheReq),
    .icacheAddr    (icacheAddr),
    .icacheValid   (icacheValid),
    .icacheInstr   (icacheInstr),
    .predInstrValid(predInstrValid),
    .predAddr      (predAddr),
    .predJump      (predJump),
    .queueFull     (queueFull),
    .pushValid     (pushValid),
    .pushInstr     (pushInstr),
    .pushPc        (pushPc),
    .pushJump      (pushJump),
    .redirectValid (redirectValid),
    .redirectAddr  (redirectAddr)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // One-cycle redirect from a FETCH/DISPATCH/STALL state; ends in FETCH at addr.
  task automatic redirect_to(input logic [31:0] addr);
    redirectValid = 1'b1;
    redirectAddr  = addr;
    next_cycle();
    redirectValid = 1'b0;
    #1;
  endtask

  // From FETCH, deliver the instruction in WAIT; ends in DISPATCH.
  task automatic run_to_dispatch(input logic [31:0] ins, input logic pj);
    next_cycle();
    icacheValid = 1'b1;
    icacheInstr = ins;
    next_cycle();
    icacheValid = 1'b0;
    predJump    = pj;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (icacheReq !== 1'b1 || icacheAddr !== 32'h100 || predAddr !== 32'h100 ||
        pushValid !== 1'b0 || predInstrValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: req=%b addr=%h paddr=%h push=%b piv=%b, want 1 100 100 0 0",
               icacheReq, icacheAddr, predAddr, pushValid, predInstrValid);
    end
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_sequential();
    checks++;
    if (icacheReq !== 1'b1 || icacheAddr !== 32'h100) begin
      failures++;
      $display("FAIL seq_c0: req=%b addr=%h, want 1 00000100", icacheReq, icacheAddr);
    end
    next_cycle();
    checks++;
    if (predInstrValid !== 1'b1 || icacheReq !== 1'b0 || pushValid !== 1'b0) begin
      failures++;
      $display("FAIL seq_wait: piv=%b req=%b push=%b, want 1 0 0", predInstrValid, icacheReq, pushValid);
    end
    icacheValid = 1'b1;
    icacheInstr = ADDI;
    next_cycle();
    icacheValid = 1'b0;
    #1;
    checks++;
    if (pushValid !== 1'b1 || pushPc !== 32'h100 || pushInstr !== ADDI || pushJump !== 1'b0) begin
      failures++;
      $display("FAIL seq_push: v=%b pc=%h ins=%h j=%b, want 1 00000100 %h 0",
               pushValid, pushPc, pushInstr, pushJump, ADDI);
    end
    next_cycle();
    checks++;
    if (icacheReq !== 1'b1 || icacheAddr !== 32'h104 || pushValid !== 1'b0) begin
      failures++;
      $display("FAIL seq_next: req=%b addr=%h push=%b, want 1 00000104 0", icacheReq, icacheAddr, pushValid);
    end
  endtask

  task automatic test_branch();
    redirect_to(32'h200);
    run_to_dispatch(BEQ_M8, 1'b1);
    checks++;
    if (pushValid !== 1'b1 || pushJump !== 1'b1 || pushPc !== 32'h200) begin
      failures++;
      $display("FAIL beq_taken_push: v=%b j=%b pc=%h, want 1 1 00000200", pushValid, pushJump, pushPc);
    end
    next_cycle();
    checks++;
    if (icacheAddr !== 32'h1F8 || icacheReq !== 1'b1) begin
      failures++;
      $display("FAIL beq_taken_next: addr=%h req=%b, want 000001f8 1", icacheAddr, icacheReq);
    end
    redirect_to(32'h200);
    run_to_dispatch(BEQ_M8, 1'b0);
    checks++;
    if (pushValid !== 1'b1 || pushJump !== 1'b0) begin
      failures++;
      $display("FAIL beq_nt_push: v=%b j=%b, want 1 0", pushValid, pushJump);
    end
    next_cycle();
    predJump = 1'b0;
    checks++;
    if (icacheAddr !== 32'h204) begin
      failures++;
      $display("FAIL beq_nt_next: addr=%h, want 00000204", icacheAddr);
    end
  endtask

  task automatic test_jal();
    redirect_to(32'h300);
    run_to_dispatch(JAL_800, 1'b0);
    checks++;
    if (pushValid !== 1'b1 || pushJump !== 1'b1 || pushPc !== 32'h300) begin
      failures++;
      $display("FAIL jal_push: v=%b j=%b pc=%h, want 1 1 00000300", pushValid, pushJump, pushPc);
    end
    next_cycle();
    checks++;
    if (icacheAddr !== 32'hB00) begin
      failures++;
      $display("FAIL jal_next: addr=%h, want 00000b00", icacheAddr);
    end
    redirect_to(32'hFFFF_FFFC);
    run_to_dispatch(JAL_8, 1'b0);
    next_cycle();
    checks++;
    if (icacheAddr !== 32'h4 || icacheReq !== 1'b1) begin
      failures++;
      $display("FAIL jal_wrap: addr=%h req=%b, want 00000004 1", icacheAddr, icacheReq);
    end
  endtask

  task automatic test_jalr_stall();
    int bad = 0;
    redirect_to(32'h500);
    run_to_dispatch(JALR, 1'b1);
    checks++;
    if (pushValid !== 1'b1 || pushJump !== 1'b0 || pushInstr !== JALR) begin
      failures++;
      $display("FAIL jalr_push: v=%b j=%b ins=%h, want 1 0 %h", pushValid, pushJump, pushInstr, JALR);
    end
    predJump = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      if (icacheReq !== 1'b0 || pushValid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL jalr_stall: %0d of 10 cycles had req/push active, want 0", bad);
    end
    redirect_to(32'h4000);
    checks++;
    if (icacheReq !== 1'b1 || icacheAddr !== 32'h4000) begin
      failures++;
      $display("FAIL jalr_redirect: req=%b addr=%h, want 1 00004000", icacheReq, icacheAddr);
    end
  endtask

  task automatic test_queue_full();
    int bad = 0;
    redirect_to(32'h600);
    queueFull = 1'b1;
    run_to_dispatch(ADDI, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (pushValid !== 1'b0 || pushPc !== 32'h600 || pushInstr !== ADDI) bad++;
      next_cycle();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL qfull_hold: %0d of 5 cycles wrong (push or data moved), want 0", bad);
    end
    queueFull = 1'b0;
    #1;
    checks++;
    if (pushValid !== 1'b1 || pushPc !== 32'h600) begin
      failures++;
      $display("FAIL qfull_release: v=%b pc=%h, want 1 00000600", pushValid, pushPc);
    end
    next_cycle();
    checks++;
    if (pushValid !== 1'b0 || icacheAddr !== 32'h604 || icacheReq !== 1'b1) begin
      failures++;
      $display("FAIL qfull_single: v=%b addr=%h req=%b, want 0 00000604 1", pushValid, icacheAddr, icacheReq);
    end
  endtask

  task automatic test_redirect_wait();
    int bad = 0;
    redirect_to(32'h700);
    next_cycle();                       // WAIT
    redirectValid = 1'b1;
    redirectAddr  = 32'h800;
    #1;
    if (pushValid !== 1'b0) bad++;
    next_cycle();                       // DROP
    redirectValid = 1'b0;
    #1;
    if (icacheReq !== 1'b0 || predInstrValid !== 1'b0 || pushValid !== 1'b0) bad++;
    next_cycle();                       // still DROP, late response arrives
    icacheValid = 1'b1;
    icacheInstr = ADDI;
    #1;
    if (icacheReq !== 1'b0 || pushValid !== 1'b0) bad++;
    next_cycle();
    icacheValid = 1'b0;
    #1;
    checks++;
    if (bad != 0 || icacheReq !== 1'b1 || icacheAddr !== 32'h800 || pushValid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_drop: bad=%0d req=%b addr=%h push=%b, want 0 1 00000800 0",
               bad, icacheReq, icacheAddr, pushValid);
    end
    next_cycle();                       // WAIT
    redirectValid = 1'b1;
    redirectAddr  = 32'h900;
    icacheValid   = 1'b1;
    icacheInstr   = ADDI;
    #1;
    bad = (pushValid !== 1'b0) ? 1 : 0;
    next_cycle();
    redirectValid = 1'b0;
    icacheValid   = 1'b0;
    #1;
    checks++;
    if (bad != 0 || icacheReq !== 1'b1 || icacheAddr !== 32'h900 || pushValid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_coincident: bad=%0d req=%b addr=%h push=%b, want 0 1 00000900 0",
               bad, icacheReq, icacheAddr, pushValid);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();                       // WAIT at 0x900
    rst = 1'b1;
    #1;
    checks++;
    if (icacheReq !== 1'b1 || icacheAddr !== 32'h100 || predInstrValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: req=%b addr=%h piv=%b, want 1 00000100 0", icacheReq, icacheAddr, predInstrValid);
    end
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    icacheValid   = 1'b0;
    icacheInstr   = 32'h0;
    predJump      = 1'b0;
    queueFull     = 1'b0;
    redirectValid = 1'b0;
    redirectAddr  = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_jalr_stall();
    test_queue_full();
    test_redirect_wait();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
